// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Arbitrates fetch / load / store / exception requests onto a
//            single memory port with a fixed MEM_LAT-cycle access, drives the
//            address mux selector (iord) and the write enable, and reports
//            completion. Optional misalignment check for data accesses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   MEM_LAT       memory latency in cycles (1..15)
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   fetch_req     instruction fetch request (address from PC)
//   load_req      data read request (address from ALUOut)
//   store_req     data write request (address from ALUOut)
//   exc_req       exception vector read request (exception address)
//   addr_lo[1:0]  ALUOut[1:0] of the data access
//   iord[2:0]     address mux select: 0 = PC, 1 = exception, 3 = ALUOut
//   mem_wr        memory write enable
//   grant[3:0]    one-hot owner: [3] exc, [2] store, [1] load, [0] fetch
//   done          one-cycle completion pulse
//   busy          high whenever the controller is not idle
//   misalign_err  one-cycle pulse when a data access is rejected
// Configuration macro:
//   MEM_ACCESS_MISALIGN_CHK_EN  enables the data misalignment check
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_req,
    input  logic       load_req,
    input  logic       store_req,
    input  logic       exc_req,
    input  logic [1:0] addr_lo,
    output logic [2:0] iord,
    output logic       mem_wr,
    output logic [3:0] grant,
    output logic       done,
    output logic       busy,
    output logic       misalign_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] grant_q, grant_d;
    logic       mis_q,   mis_d;
    logic       data_misaligned;

`ifdef MEM_ACCESS_MISALIGN_CHK_EN
    assign data_misaligned = (addr_lo != 2'b00);
`else
    logic unused_addr_lo;
    assign unused_addr_lo  = ^addr_lo;
    assign data_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            grant_q <= 4'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        mis_d   = mis_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                mis_d = 1'b0;
                // Fixed priority: exc > store > load > fetch.
                if (exc_req)        grant_d = 4'b1000;
                else if (store_req) grant_d = 4'b0100;
                else if (load_req)  grant_d = 4'b0010;
                else if (fetch_req) grant_d = 4'b0001;
                else                grant_d = 4'b0000;
                if (grant_d != 4'b0000) begin
                    // A rejected data access bypasses ACCESS entirely so the
                    // memory never sees a write strobe for it.
                    if ((grant_d[2] || grant_d[1]) && data_misaligned) begin
                        state_d = DONE;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = 4'd1;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == LAT) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = 4'd0;
                mis_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                grant_d = 4'd0;
                mis_d   = 1'b0;
            end
        endcase
    end

    // Outputs decode purely from registers, so reset clears them at once.
    always_comb begin
        iord = 3'd0;
        if (grant_q[3])                   iord = 3'd1;
        else if (grant_q[2] || grant_q[1]) iord = 3'd3;
    end

    assign grant  = grant_q;
    assign busy   = (state_q != IDLE);
    assign mem_wr = (state_q == ACCESS) && grant_q[2];
    assign done   = (state_q == DONE) && !mis_q;

`ifdef MEM_ACCESS_MISALIGN_CHK_EN
    assign misalign_err = (state_q == DONE) && mis_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

`default_nettype wire
